// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction-fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, inst} entries with a registered head so decode sees flop outputs.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_after_pop;
  fetch_entry_t  head_nxt;
  logic          do_pop;

  // The head register is preloaded with whatever entry will sit at the read pointer next cycle.
  always_comb begin
    do_pop          = pop && (count != '0);
    rd_ptr_nxt      = rd_ptr + PW'(do_pop);
    count_after_pop = count - CW'(do_pop);
    head_nxt        = head;
    if (count_after_pop != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end else if (push) begin
      head_nxt = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '{pc: '0, inst: INST_NOP};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count_after_pop + CW'(push);
      head  <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled fetch front end: PC generation, imem request credits and stale-response dropping.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   outst_nxt;
  logic [OW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic            accept;
  logic            push;
  logic            pop;
  logic            dropping;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every outstanding request holds a FIFO slot, so a kept response can never overflow.
  always_comb begin
    imem_req_valid_o = rst && (outst < OW'(MAX_OUTST))
                       && ((int'(outst) + int'(count)) < int'(DEPTH));
    imem_req_addr_o  = fetch_pc;
    accept           = imem_req_valid_o && imem_req_ready_i;
    outst_nxt        = outst + OW'(accept) - OW'(imem_rsp_valid_i);
    dropping         = imem_rsp_valid_i && (drop_cnt != '0);
    push             = imem_rsp_valid_i && (drop_cnt == '0) && !redirect_i;
    pop              = inst_valid_o && inst_ready_i;
    target_pc        = {redirect_pc_i[XLEN-1:2], 2'b00};
    push_entry.pc    = rsp_pc;
    push_entry.inst  = imem_rsp_data_i;
    inst_valid_o     = (count != '0);
    inst_o           = head.inst;
    inst_pc_o        = head.pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_VEC;
      rsp_pc   <= RESET_VEC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_i) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= outst_nxt;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (dropping) begin
          drop_cnt <= drop_cnt - OW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst && imem_rsp_valid_i) begin
      assert (outst != '0);
      if (drop_cnt == '0) begin
        assert ((count < CW'(DEPTH)) || pop);
      end
    end
  end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised, decoupled instruction-fetch front end for the RISC-V core; replaces the single-register PC/instruction-latch path. Issues in-order requests to instruction memory via a valid/ready request channel with variable-latency responses, buffers returned instructions with their PCs in a prefetch FIFO, and presents them to decode through a valid/ready handshake. Redirects from execute (branch/jump) flush the buffer and discard stale in-flight responses.

## Interface
- XLEN, 32, address/PC width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MAX_OUTST, 2, maximum outstanding imem requests; 1..DEPTH
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  imem accepts request
- imem_req_addr_o  out  XLEN  fetch address, word-aligned
- imem_rsp_valid_i  in  1  response valid; responses return in request order, one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data_i  in  32  instruction word
- redirect_i  in  1  one-cycle redirect pulse from execute
- redirect_pc_i  in  XLEN  redirect target
- inst_valid_o  out  1  instruction available to decode
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  instruction word
- inst_pc_o  out  XLEN  PC of inst_o

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next kept response), outst (accepted, not yet returned), drop_cnt (returns to discard), FIFO count.
- Request issue: imem_req_valid_o = 1 when outst < MAX_OUTST and outst + count < DEPTH (slot reserved per outstanding request); addr = fetch_pc. On accept: fetch_pc += 4, outst += 1.
- Response: outst -= 1. If drop_cnt > 0: discard, drop_cnt -= 1. Else push {rsp_pc, data}, rsp_pc += 4.
- Pop: inst_valid_o & inst_ready_i removes head.
- Redirect (priority over push/issue bookkeeping): FIFO emptied; fetch_pc and rsp_pc <= redirect_pc_i; drop_cnt <= outst_next (outst + accept − rsp this cycle); response arriving in the redirect cycle is discarded. A request accepted in the redirect cycle carries the old address and is counted in drop_cnt.
- Handshake: once imem_req_valid_o is high it stays high with stable address until accepted, except a redirect may change the address in the following cycle.
- PC arithmetic modulo 2^XLEN; wrap at top of address space is silent.
- redirect_pc_i[1:0] ignored (forced 0).

## Timing
- Reset values: imem_req_valid_o 0, imem_req_addr_o RESET_VEC, inst_valid_o 0, inst_o 32'h0000_0013, inst_pc_o 0; fetch_pc = rsp_pc = RESET_VEC; outst = drop_cnt = count = 0.
- First request asserted in first cycle after rst deasserts.
- Latency: response in cycle M -> inst_valid_o in M+1 (no combinational bypass). Zero-wait imem sustains 1 instruction/cycle when MAX_OUTST ≥ 2.
- Redirect in cycle R: inst_valid_o = 0 in R+1; first request to target in R+1.
- Simultaneous pop and redirect: pop completes (decode owns that instruction), then flush.
- Simultaneous push and pop on full FIFO: both occur, count unchanged.
- Response with FIFO full and drop_cnt = 0 is impossible by credit rule; assertion required.
- rst mid-operation: all state cleared immediately; responses for pre-reset requests are outside contract.

## Structure
- riscv_pkg: XLEN default, INST_NOP = 32'h0000_0013, typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, push/pop/flush, count output, registered head.
- Top: PC/credit/drop logic only.

## Test plan
- Reset, zero-wait imem, inst_ready_i=1: requests 0x0,0x4,0x8…; inst_o/inst_pc_o stream in order at 1/cycle from cycle 3.
- inst_ready_i=0 for 10 cycles: exactly DEPTH entries buffered, imem_req_valid_o drops, no overflow; resume -> PCs continue without gap.
- imem latency 3, two requests outstanding, redirect to 0x100: both stale responses discarded, next inst_pc_o = 0x100.
- Redirect in same cycle as response and request accept: that response dropped, accepted request dropped later, drop_cnt returns to 0.
- imem_req_ready_i toggling: address held stable while valid and not ready.
- rst asserted with FIFO half full: all outputs at reset values asynchronously; restart at RESET_VEC.
